// File: rtl/dragonfang_pkg.sv
// Shared definitions for the dragonfang vector issue path: register tag
// width, default sizing and the decoded-instruction record held at issue.
package dragonfang_pkg;

  localparam int TAG_LENGTH              = 5;
  localparam int NUM_VREGS_DEFAULT       = 2 ** TAG_LENGTH;
  localparam int MAX_OUTSTANDING_DEFAULT = 8;
  localparam int STALL_CNT_WIDTH_DEFAULT = 16;

  typedef logic [TAG_LENGTH-1:0] vreg_tag_t;

  // Everything the issue stage needs to know about one decoded instruction.
  typedef struct packed {
    vreg_tag_t vs1_address;
    vreg_tag_t vs2_address;
    vreg_tag_t vd_address;
    logic      uses_vs1;
    logic      uses_vs2;
    logic      uses_vd;
    logic      masked;
    logic      writes_vd;
  } issue_request_t;

  // Issue controller states: nothing held, held but hazarded, presented to register read.
  typedef enum logic [1:0] {
    ISSUE_EMPTY = 2'd0,
    ISSUE_WAIT  = 2'd1,
    ISSUE_VALID = 2'd2
  } issue_state_t;

endpackage

// File: rtl/vector_hazard_check.sv
// Combinational hazard evaluation for the held vector instruction: RAW on
// vs1/vs2/v0-mask, WAW (and read-modify-write) on vd, and write credits.
module vector_hazard_check
  import dragonfang_pkg::*;
#(
  parameter int NUM_VREGS = NUM_VREGS_DEFAULT
) (
  input  issue_request_t       req,
  input  logic [NUM_VREGS-1:0] busy_vector,
  input  logic                 wb_valid,
  input  logic [TAG_LENGTH-1:0] wb_address,
  input  logic                 credits_at_max,
  output logic                 hazard
);

  logic [NUM_VREGS-1:0] eff_busy;
  logic                 credits_full;
  logic                 vs1_hit;
  logic                 vs2_hit;
  logic                 vd_hit;
  logic                 mask_hit;

  // A register retiring this cycle is treated as free; register read forwards it.
  always_comb begin
    eff_busy = busy_vector;
    if (wb_valid) begin
      eff_busy[wb_address] = 1'b0;
    end
  end

  // A write-back that actually retires a pending writer frees a credit this cycle.
  always_comb begin
    credits_full = credits_at_max & ~(wb_valid & busy_vector[wb_address]);
  end

  // Combine source reads, destination ordering, mask read and credit pressure.
  always_comb begin
    vs1_hit  = req.uses_vs1 & eff_busy[req.vs1_address];
    vs2_hit  = req.uses_vs2 & eff_busy[req.vs2_address];
    vd_hit   = (req.uses_vd | req.writes_vd) & eff_busy[req.vd_address];
    mask_hit = req.masked & eff_busy[0];
    hazard   = vs1_hit | vs2_hit | vd_hit | mask_hit | (req.writes_vd & credits_full);
  end

endmodule

// File: rtl/vector_issue_scoreboard.sv
// In-order vector issue controller. Holds one decoded instruction until its
// register hazards clear and a write credit is free, then presents the
// register addresses to register read. Write-backs retire busy registers.
module vector_issue_scoreboard
  import dragonfang_pkg::*;
#(
  parameter int  NUM_VREGS       = NUM_VREGS_DEFAULT,
  parameter int  MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int  STALL_CNT_WIDTH = STALL_CNT_WIDTH_DEFAULT,
  localparam int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       dec_valid,
  output logic                       dec_ready,
  input  logic [TAG_LENGTH-1:0]      dec_vs1_address,
  input  logic [TAG_LENGTH-1:0]      dec_vs2_address,
  input  logic [TAG_LENGTH-1:0]      dec_vd_address,
  input  logic                       dec_uses_vs1,
  input  logic                       dec_uses_vs2,
  input  logic                       dec_uses_vd,
  input  logic                       dec_masked,
  input  logic                       dec_writes_vd,
  output logic                       rr_valid,
  input  logic                       rr_ready,
  output logic [TAG_LENGTH-1:0]      rr_v0_address,
  output logic [TAG_LENGTH-1:0]      rr_vs1_address,
  output logic [TAG_LENGTH-1:0]      rr_vs2_address,
  output logic [TAG_LENGTH-1:0]      rr_vd_address,
  input  logic                       wb_valid,
  input  logic [TAG_LENGTH-1:0]      wb_address,
  output logic [NUM_VREGS-1:0]       busy_vector,
  output logic [OUT_WIDTH-1:0]       outstanding,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  issue_state_t         state;
  issue_request_t       hold_req;
  issue_request_t       dec_req;
  logic                 hazard;
  logic                 credits_at_max;
  logic                 handshake;
  logic                 issue_set;
  logic                 wb_clear;
  logic [NUM_VREGS-1:0] wb_onehot;
  logic [NUM_VREGS-1:0] vd_onehot;

  // Pack the decoder fields into the record that the hold register stores.
  always_comb begin
    dec_req             = '0;
    dec_req.vs1_address = dec_vs1_address;
    dec_req.vs2_address = dec_vs2_address;
    dec_req.vd_address  = dec_vd_address;
    dec_req.uses_vs1    = dec_uses_vs1;
    dec_req.uses_vs2    = dec_uses_vs2;
    dec_req.uses_vd     = dec_uses_vd;
    dec_req.masked      = dec_masked;
    dec_req.writes_vd   = dec_writes_vd;
  end

  assign credits_at_max = (outstanding == OUT_WIDTH'(MAX_OUTSTANDING));

  vector_hazard_check #(
    .NUM_VREGS (NUM_VREGS)
  ) hazard_check (
    .req            (hold_req),
    .busy_vector    (busy_vector),
    .wb_valid       (wb_valid),
    .wb_address     (wb_address),
    .credits_at_max (credits_at_max),
    .hazard         (hazard)
  );

  // A flushed handshake is not an issue, so it must not claim vd.
  assign handshake = rr_valid & rr_ready & ~flush;
  assign issue_set = handshake & hold_req.writes_vd;
  assign wb_clear  = wb_valid & busy_vector[wb_address];

  // Single-bit masks for the retiring register and the newly claimed destination.
  always_comb begin
    wb_onehot                      = '0;
    vd_onehot                      = '0;
    wb_onehot[wb_address]          = wb_clear;
    vd_onehot[hold_req.vd_address] = issue_set;
  end

  // Accept from decode when empty, or when the presented instruction leaves this cycle.
  always_comb begin
    case (state)
      ISSUE_EMPTY: dec_ready = 1'b1;
      ISSUE_VALID: dec_ready = rr_ready;
      default:     dec_ready = 1'b0;
    endcase
  end

  // Issue FSM: capture, wait out hazards, present until register read takes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ISSUE_EMPTY;
      hold_req <= '0;
      rr_valid <= 1'b0;
    end else if (flush) begin
      state    <= ISSUE_EMPTY;
      rr_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE_EMPTY: begin
          if (dec_valid) begin
            hold_req <= dec_req;
            state    <= ISSUE_WAIT;
          end
        end
        ISSUE_WAIT: begin
          if (!hazard) begin
            state    <= ISSUE_VALID;
            rr_valid <= 1'b1;
          end
        end
        ISSUE_VALID: begin
          if (rr_ready) begin
            rr_valid <= 1'b0;
            if (dec_valid) begin
              hold_req <= dec_req;
              state    <= ISSUE_WAIT;
            end else begin
              state <= ISSUE_EMPTY;
            end
          end
        end
        default: begin
          state    <= ISSUE_EMPTY;
          rr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Busy bits: retire first, then claim, so a same-cycle claim of the same register wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_vector <= '0;
    end else begin
      busy_vector <= (busy_vector & ~wb_onehot) | vd_onehot;
    end
  end

  // In-flight writer count tracks claims and genuine retirements only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({issue_set, wb_clear})
        2'b10:   outstanding <= outstanding + OUT_WIDTH'(1);
        2'b01:   outstanding <= outstanding - OUT_WIDTH'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Count every cycle the held instruction is blocked, sticking at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if ((state == ISSUE_WAIT) && hazard && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
    end
  end

  assign rr_v0_address  = '0;
  assign rr_vs1_address = hold_req.vs1_address;
  assign rr_vs2_address = hold_req.vs2_address;
  assign rr_vd_address  = hold_req.vd_address;

endmodule

// File: tb/tb_vector_issue_scoreboard.sv
// Testbench for vector_issue_scoreboard: directed scenarios followed by
// random traffic, all compared cycle by cycle with a rule-level model.
module tb_vector_issue_scoreboard;
  import dragonfang_pkg::*;

  localparam int NVR       = 32;
  localparam int MAXO      = 2;
  localparam int SCW       = 5;
  localparam int OUTW      = $clog2(MAXO + 1);
  localparam int STALL_MAX = (1 << SCW) - 1;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             dec_valid;
  logic             dec_ready;
  logic [4:0]       dec_vs1_address;
  logic [4:0]       dec_vs2_address;
  logic [4:0]       dec_vd_address;
  logic             dec_uses_vs1;
  logic             dec_uses_vs2;
  logic             dec_uses_vd;
  logic             dec_masked;
  logic             dec_writes_vd;
  logic             rr_valid;
  logic             rr_ready;
  logic [4:0]       rr_v0_address;
  logic [4:0]       rr_vs1_address;
  logic [4:0]       rr_vs2_address;
  logic [4:0]       rr_vd_address;
  logic             wb_valid;
  logic [4:0]       wb_address;
  logic [NVR-1:0]   busy_vector;
  logic [OUTW-1:0]  outstanding;
  logic [SCW-1:0]   stall_cycles;

  int compared   = 0;
  int mismatched = 0;

  // Model of the scoreboard, kept as plain rules over registers and counts.
  bit             m_busy [NVR];
  int             m_out;
  int             m_stall;
  bit             m_has;
  bit             m_pres;
  issue_request_t m_req;

  // Outputs observed just before the most recent clock edge.
  logic       last_rr_valid;
  logic       last_dec_ready;
  logic [4:0] last_v0;
  logic [4:0] last_vs1;
  logic [4:0] last_vs2;
  logic [4:0] last_vd;

  vector_issue_scoreboard #(
    .NUM_VREGS       (NVR),
    .MAX_OUTSTANDING (MAXO),
    .STALL_CNT_WIDTH (SCW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush           (flush),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_vs1_address (dec_vs1_address),
    .dec_vs2_address (dec_vs2_address),
    .dec_vd_address  (dec_vd_address),
    .dec_uses_vs1    (dec_uses_vs1),
    .dec_uses_vs2    (dec_uses_vs2),
    .dec_uses_vd     (dec_uses_vd),
    .dec_masked      (dec_masked),
    .dec_writes_vd   (dec_writes_vd),
    .rr_valid        (rr_valid),
    .rr_ready        (rr_ready),
    .rr_v0_address   (rr_v0_address),
    .rr_vs1_address  (rr_vs1_address),
    .rr_vs2_address  (rr_vs2_address),
    .rr_vd_address   (rr_vd_address),
    .wb_valid        (wb_valid),
    .wb_address      (wb_address),
    .busy_vector     (busy_vector),
    .outstanding     (outstanding),
    .stall_cycles    (stall_cycles)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic issue_request_t mkReq(input int vs1, input int vs2, input int vd,
                                           input bit u1, input bit u2, input bit uvd,
                                           input bit msk, input bit wvd);
    issue_request_t r;
    r.vs1_address = vreg_tag_t'(vs1);
    r.vs2_address = vreg_tag_t'(vs2);
    r.vd_address  = vreg_tag_t'(vd);
    r.uses_vs1    = u1;
    r.uses_vs2    = u2;
    r.uses_vd     = uvd;
    r.masked      = msk;
    r.writes_vd   = wvd;
    return r;
  endfunction

  function automatic logic [31:0] modelBusy();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NVR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NVR; i++) m_busy[i] = 1'b0;
    m_out   = 0;
    m_stall = 0;
    m_has   = 1'b0;
    m_pres  = 1'b0;
    m_req   = '0;
  endfunction

  // The held instruction may not leave while any register it touches has a
  // pending writer (unless that writer retires now), or while it needs a
  // credit and every credit is taken with none being returned this cycle.
  function automatic bit modelBlocked(input logic wv, input int wa);
    int needed[$];
    bit blocked;
    bit frees_credit;
    blocked      = 1'b0;
    frees_credit = wv && m_busy[wa];
    if (m_req.uses_vs1) needed.push_back(int'(m_req.vs1_address));
    if (m_req.uses_vs2) needed.push_back(int'(m_req.vs2_address));
    if (m_req.uses_vd || m_req.writes_vd) needed.push_back(int'(m_req.vd_address));
    if (m_req.masked) needed.push_back(0);
    foreach (needed[i]) begin
      if (m_busy[needed[i]] && !(wv && wa == needed[i])) blocked = 1'b1;
    end
    if (m_req.writes_vd && m_out == MAXO && !frees_credit) blocked = 1'b1;
    return blocked;
  endfunction

  function automatic void modelStep(input logic dv, input issue_request_t r, input logic rrr,
                                    input logic wv, input int wa, input logic fl);
    bit blocked;
    bit issued;
    blocked = m_has && !m_pres && modelBlocked(wv, wa);
    if (blocked) m_stall = (m_stall >= STALL_MAX) ? STALL_MAX : m_stall + 1;
    issued = m_pres && rrr && !fl;
    if (wv && m_busy[wa]) begin
      m_busy[wa] = 1'b0;
      m_out--;
    end
    if (issued && m_req.writes_vd) begin
      m_busy[m_req.vd_address] = 1'b1;
      m_out++;
    end
    if (fl) begin
      m_has  = 1'b0;
      m_pres = 1'b0;
    end else if (!m_has) begin
      if (dv) begin
        m_has  = 1'b1;
        m_pres = 1'b0;
        m_req  = r;
      end
    end else if (!m_pres) begin
      if (!blocked) m_pres = 1'b1;
    end else if (rrr) begin
      if (dv) begin
        m_req  = r;
        m_pres = 1'b0;
      end else begin
        m_has  = 1'b0;
        m_pres = 1'b0;
      end
    end
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance model, check state.
  task automatic applyStimulus(input logic dv, input issue_request_t r, input logic rrr,
                               input logic wv, input int wa, input logic fl);
    logic exp_ready;
    dec_valid       = dv;
    dec_vs1_address = r.vs1_address;
    dec_vs2_address = r.vs2_address;
    dec_vd_address  = r.vd_address;
    dec_uses_vs1    = r.uses_vs1;
    dec_uses_vs2    = r.uses_vs2;
    dec_uses_vd     = r.uses_vd;
    dec_masked      = r.masked;
    dec_writes_vd   = r.writes_vd;
    rr_ready        = rrr;
    wb_valid        = wv;
    wb_address      = 5'(wa);
    flush           = fl;
    #1;
    last_rr_valid  = rr_valid;
    last_dec_ready = dec_ready;
    last_v0        = rr_v0_address;
    last_vs1       = rr_vs1_address;
    last_vs2       = rr_vs2_address;
    last_vd        = rr_vd_address;
    exp_ready = !m_has ? 1'b1 : (m_pres ? rrr : 1'b0);
    checkOutput("rr_valid", 32'(rr_valid), 32'(m_pres));
    checkOutput("dec_ready", 32'(dec_ready), 32'(exp_ready));
    if (m_pres) begin
      checkOutput("rr_v0_address", 32'(rr_v0_address), 32'd0);
      checkOutput("rr_vs1_address", 32'(rr_vs1_address), 32'(m_req.vs1_address));
      checkOutput("rr_vs2_address", 32'(rr_vs2_address), 32'(m_req.vs2_address));
      checkOutput("rr_vd_address", 32'(rr_vd_address), 32'(m_req.vd_address));
    end
    modelStep(dv, r, rrr, wv, wa, fl);
    @(posedge clock);
    #1;
    checkOutput("busy_vector", busy_vector, modelBusy());
    checkOutput("outstanding", 32'(outstanding), 32'(m_out));
    checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stall));
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_rr_valid"}, 32'(rr_valid), 32'd0);
    checkOutput({tag, "_dec_ready"}, 32'(dec_ready), 32'd1);
    checkOutput({tag, "_busy"}, busy_vector, 32'd0);
    checkOutput({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall_cycles), 32'd0);
    checkOutput({tag, "_vs1"}, 32'(rr_vs1_address), 32'd0);
    checkOutput({tag, "_vd"}, 32'(rr_vd_address), 32'd0);
  endtask

  initial begin
    issue_request_t idle;
    issue_request_t rq;
    idle = mkReq(0, 0, 0, 0, 0, 0, 0, 0);

    reset_n = 1'b0;
    applyIdleInputs(idle);
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    $display("[TB] reset values");
    resetChecks("reset");
    reset_n = 1'b1;

    $display("[TB] basic issue latency");
    applyStimulus(1, mkReq(3, 4, 5, 1, 1, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("a_wait_rr_valid", 32'(last_rr_valid), 32'd0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("a_latency_rr_valid", 32'(last_rr_valid), 32'd1);
    checkOutput("a_v0", 32'(last_v0), 32'd0);
    checkOutput("a_vs1", 32'(last_vs1), 32'd3);
    checkOutput("a_vs2", 32'(last_vs2), 32'd4);
    checkOutput("a_vd", 32'(last_vd), 32'd5);
    checkOutput("a_busy5", 32'(busy_vector[5]), 32'd1);
    checkOutput("a_outstanding", 32'(outstanding), 32'd1);

    $display("[TB] RAW stall with write-back bypass");
    applyStimulus(1, mkReq(5, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0, 0);
    repeat (3) applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("raw_stall3", 32'(stall_cycles), 32'd3);
    applyStimulus(0, idle, 1, 1, 5, 0);
    checkOutput("raw_rr_before_wb", 32'(last_rr_valid), 32'd0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("raw_rr_after_wb", 32'(last_rr_valid), 32'd1);
    checkOutput("raw_stall_final", 32'(stall_cycles), 32'd3);
    checkOutput("raw_busy5_clear", 32'(busy_vector[5]), 32'd0);

    $display("[TB] WAW plus mask");
    applyStimulus(1, mkReq(0, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 7, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 7, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("waw_busy_0_7", busy_vector, 32'h0000_0081);
    checkOutput("waw_outstanding2", 32'(outstanding), 32'd2);
    applyStimulus(1, mkReq(0, 0, 7, 0, 0, 0, 1, 1), 1, 0, 0, 0);
    repeat (2) applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 1, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("waw_still_held", 32'(last_rr_valid), 32'd0);
    applyStimulus(0, idle, 1, 1, 7, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("waw_released", 32'(last_rr_valid), 32'd1);
    checkOutput("waw_stall", 32'(stall_cycles), 32'd7);
    checkOutput("waw_busy_after", busy_vector, 32'h0000_0080);

    $display("[TB] credit limit");
    applyStimulus(0, idle, 1, 1, 7, 0);
    applyStimulus(1, mkReq(0, 0, 1, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 2, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 2, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 3, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 3, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("cred_full_out", 32'(outstanding), 32'd2);
    checkOutput("cred_stall", 32'(stall_cycles), 32'd8);
    applyStimulus(0, idle, 1, 1, 1, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("cred_issued", 32'(last_rr_valid), 32'd1);
    checkOutput("cred_out_after", 32'(outstanding), 32'd2);
    checkOutput("cred_busy_after", busy_vector, 32'h0000_000C);

    $display("[TB] back-to-back issue");
    applyStimulus(0, idle, 1, 1, 2, 0);
    applyStimulus(0, idle, 1, 1, 3, 0);
    applyStimulus(1, mkReq(11, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 9, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(1, mkReq(0, 0, 9, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    checkOutput("b2b_accept1", 32'(last_dec_ready), 32'd1);
    applyStimulus(1, mkReq(12, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkReq(12, 0, 0, 1, 0, 0, 0, 0), 1, 1, 9, 0);
    checkOutput("b2b_accept2", 32'(last_dec_ready), 32'd1);
    checkOutput("b2b_busy9_set_wins", 32'(busy_vector[9]), 32'd1);
    checkOutput("b2b_outstanding", 32'(outstanding), 32'd1);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 1, 9, 0);

    $display("[TB] flush and stray write-back");
    applyStimulus(1, mkReq(0, 0, 6, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 1);
    checkOutput("flush_was_valid", 32'(last_rr_valid), 32'd1);
    checkOutput("flush_busy6", 32'(busy_vector[6]), 32'd0);
    checkOutput("flush_rr_valid", 32'(rr_valid), 32'd0);
    checkOutput("flush_dec_ready", 32'(dec_ready), 32'd1);
    applyStimulus(1, mkReq(0, 0, 11, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 1, 10, 0);
    checkOutput("stray_wb_out", 32'(outstanding), 32'd1);
    checkOutput("stray_wb_busy", busy_vector, 32'h0000_0800);
    applyStimulus(0, idle, 1, 1, 11, 0);

    $display("[TB] stall counter saturation");
    applyStimulus(1, mkReq(0, 0, 20, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(0, idle, 1, 0, 0, 0);
    applyStimulus(1, mkReq(20, 0, 0, 1, 0, 0, 0, 0), 1, 0, 0, 0);
    repeat (40) applyStimulus(0, idle, 1, 0, 0, 0);
    checkOutput("sat_stall", 32'(stall_cycles), STALL_MAX);
    checkOutput("sat_held", 32'(rr_valid), 32'd0);

    $display("[TB] asynchronous reset while waiting");
    #2;
    reset_n = 1'b0;
    #1;
    resetChecks("async_reset");
    modelReset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      rq = mkReq(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      applyStimulus(1'($urandom_range(0, 9) < 7), rq, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  task automatic applyIdleInputs(input issue_request_t r);
    flush           = 1'b0;
    dec_valid       = 1'b0;
    dec_vs1_address = r.vs1_address;
    dec_vs2_address = r.vs2_address;
    dec_vd_address  = r.vd_address;
    dec_uses_vs1    = r.uses_vs1;
    dec_uses_vs2    = r.uses_vs2;
    dec_uses_vd     = r.uses_vd;
    dec_masked      = r.masked;
    dec_writes_vd   = r.writes_vd;
    rr_ready        = 1'b0;
    wb_valid        = 1'b0;
    wb_address      = '0;
  endtask

endmodule
